// File: rtl/pio_cmd_sequencer_pkg.sv
// Purpose: shared widths, field positions, FSM states and opcodes for the PIO command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pio_cmd_pkg;

    localparam int CMD_W  = 19;
    localparam int STAT_W = 10;
    localparam int OPC_W  = 3;
    localparam int ARG_W  = 15;
    localparam int RES_W  = 8;

    // Command word fields (LED PIO export)
    localparam int CMD_REQ_BIT = 18;
    localparam int CMD_OPC_LSB = 15;
    localparam int CMD_ARG_LSB = 0;

    // Status word fields (switch PIO input)
    localparam int STAT_DONE_BIT = 9;
    localparam int STAT_ERR_BIT  = 8;
    localparam int STAT_RES_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Opcode 7 is reserved as the internal completion-count query
    localparam logic [OPC_W-1:0] OPC_QUERY = 3'd7;

    // Result codes reported when the coprocessor did not supply one
    localparam logic [RES_W-1:0] RES_ILLEGAL = 8'h00;
    localparam logic [RES_W-1:0] RES_TIMEOUT = 8'hFF;

endpackage

// File: rtl/pio_cmd_sequencer_watchdog.sv
// Purpose: watchdog timer for one outstanding coprocessor command (clear, enable, expiry strobe).
// Latency: expired_o is combinational from the timer; fires in the cycle the count would reach TIMEOUT_CYC-1.
// Backpressure: none; the timer only advances while en_i is high.
module cp_watchdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [16:0] LIMIT = 17'(TIMEOUT_CYC - 1);

    logic [15:0] timer_q;
    logic [15:0] timer_d;

    // Next timer value: clear wins over count
    always_comb begin
        timer_d = timer_q;
        if (clr_i) begin
            timer_d = '0;
        end else if (en_i) begin
            timer_d = timer_q + 16'd1;
        end
    end

    // Timer register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // Expiry when this cycle's increment lands on TIMEOUT_CYC-1, so WAIT lasts TIMEOUT_CYC-1 cycles
    // and status appears TIMEOUT_CYC cycles after the start pulse.
    assign expired_o = en_i && (({1'b0, timer_q} + 17'd1) == LIMIT);

endmodule

// File: rtl/pio_cmd_sequencer.sv
// Purpose: accepts HPS PIO command words, runs one coprocessor op at a time, reports done/err/result.
// Latency: req edge in cycle N -> cp_start_o in N+1; cp_done_i in cycle M -> status done in M+1.
// Backpressure: commands are accepted only on a fresh req rising edge while IDLE. Optional: PIO_CMD_COUNT_EN.
module pio_cmd_sequencer
    import pio_cmd_pkg::*;
#(
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [7:0]  OPC_VALID   = 8'b0111_1111
) (
    input  logic                clk_clk,
    input  logic                reset,
    input  logic [CMD_W-1:0]    pio_cmd_i,
    output logic [STAT_W-1:0]   pio_status_o,
    output logic                cp_start_o,
    output logic [OPC_W-1:0]    cp_op_o,
    output logic [ARG_W-1:0]    cp_arg_o,
    input  logic                cp_done_i,
    input  logic                cp_err_i,
    input  logic [RES_W-1:0]    cp_result_i,
    output logic                busy_o
);

    state_t             state_q, state_d;
    logic               req_q;
    logic [OPC_W-1:0]   op_q, op_d;
    logic [ARG_W-1:0]   arg_q, arg_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [RES_W-1:0]   result_q, result_d;
`ifdef PIO_CMD_COUNT_EN
    logic [RES_W-1:0]   cnt_q, cnt_d;
`endif

    logic               req;
    logic [OPC_W-1:0]   cmd_op;
    logic [ARG_W-1:0]   cmd_arg;
    logic               wd_expired;

    assign req     = pio_cmd_i[CMD_REQ_BIT];
    assign cmd_op  = pio_cmd_i[CMD_OPC_LSB +: OPC_W];
    assign cmd_arg = pio_cmd_i[CMD_ARG_LSB +: ARG_W];

    cp_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i     (clk_clk),
        .reset_i   (reset),
        .clr_i     (state_q == ISSUE),
        .en_i      (state_q == WAIT),
        .expired_o (wd_expired)
    );

    // Next-state and status update; done is raised on every entry into DONE
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        arg_d    = arg_q;
        done_d   = done_q;
        err_d    = err_q;
        result_d = result_q;
`ifdef PIO_CMD_COUNT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req && !req_q) begin
                    op_d   = cmd_op;
                    arg_d  = cmd_arg;
                    done_d = 1'b0;
                    err_d  = 1'b0;
`ifdef PIO_CMD_COUNT_EN
                    if (cmd_op == OPC_QUERY) begin
                        state_d  = DONE;
                        result_d = cnt_q;
                    end else
`endif
                    if (OPC_VALID[cmd_op]) begin
                        state_d = ISSUE;
                    end else begin
                        state_d  = DONE;
                        err_d    = 1'b1;
                        result_d = RES_ILLEGAL;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // A completion in the expiry cycle takes priority over the timeout
                if (cp_done_i) begin
                    state_d  = DONE;
                    err_d    = cp_err_i;
                    result_d = cp_result_i;
`ifdef PIO_CMD_COUNT_EN
                    if (!cp_err_i) begin
                        cnt_d = cnt_q + 8'd1;
                    end
`endif
                end else if (wd_expired) begin
                    state_d  = DONE;
                    err_d    = 1'b1;
                    result_d = RES_TIMEOUT;
                end
            end
            DONE: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == DONE) begin
            done_d = 1'b1;
        end
    end

    // State and status registers; req_q resets high so a req held across reset is not taken as an edge
    always_ff @(posedge clk_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b1;
            op_q     <= '0;
            arg_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
`ifdef PIO_CMD_COUNT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req;
            op_q     <= op_d;
            arg_q    <= arg_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
`ifdef PIO_CMD_COUNT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign pio_status_o[STAT_DONE_BIT]             = done_q;
    assign pio_status_o[STAT_ERR_BIT]              = err_q;
    assign pio_status_o[STAT_RES_LSB +: RES_W]     = result_q;
    assign cp_start_o = (state_q == ISSUE);
    assign cp_op_o    = (state_q == ISSUE || state_q == WAIT) ? op_q  : '0;
    assign cp_arg_o   = (state_q == ISSUE || state_q == WAIT) ? arg_q : '0;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// Purpose: directed self-checking bench for pio_cmd_sequencer (TIMEOUT_CYC=16, default opcode mask).
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: n/a.
module tb_pio_cmd_sequencer;

    logic        clk_clk = 1'b0;
    logic        reset;
    logic [18:0] pio_cmd_i;
    logic [9:0]  pio_status_o;
    logic        cp_start_o;
    logic [2:0]  cp_op_o;
    logic [14:0] cp_arg_o;
    logic        cp_done_i;
    logic        cp_err_i;
    logic [7:0]  cp_result_i;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    int good_cnt = 0;

    pio_cmd_sequencer #(
        .TIMEOUT_CYC (16),
        .OPC_VALID   (8'b0111_1111)
    ) dut (
        .clk_clk      (clk_clk),
        .reset        (reset),
        .pio_cmd_i    (pio_cmd_i),
        .pio_status_o (pio_status_o),
        .cp_start_o   (cp_start_o),
        .cp_op_o      (cp_op_o),
        .cp_arg_o     (cp_arg_o),
        .cp_done_i    (cp_done_i),
        .cp_err_i     (cp_err_i),
        .cp_result_i  (cp_result_i),
        .busy_o       (busy_o)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    // Full successful command; req must have been low for at least one cycle beforehand
    task automatic good_cmd(input logic [2:0] op, input logic [14:0] arg,
                            input logic [7:0] res, input int lat);
        pio_cmd_i = {1'b1, op, arg};
        step(1);
        check("gc_start", 32'(cp_start_o), 32'd1);
        check("gc_op",    32'(cp_op_o),    32'(op));
        check("gc_arg",   32'(cp_arg_o),   32'(arg));
        step(1 + lat);
        cp_done_i   = 1'b1;
        cp_err_i    = 1'b0;
        cp_result_i = res;
        step(1);
        cp_done_i = 1'b0;
        check("gc_status", 32'(pio_status_o), 32'({2'b10, res}));
        pio_cmd_i[18] = 1'b0;
        step(1);
        check("gc_idle", 32'(busy_o), 32'd0);
        good_cnt++;
    endtask

    initial begin
        reset       = 1'b1;
        pio_cmd_i   = '0;
        cp_done_i   = 1'b0;
        cp_err_i    = 1'b0;
        cp_result_i = '0;
        step(2);
        check("rst_status", 32'(pio_status_o), 32'h0);
        check("rst_start",  32'(cp_start_o),   32'h0);
        check("rst_busy",   32'(busy_o),       32'h0);
        check("rst_op_arg", 32'({cp_op_o, cp_arg_o}), 32'h0);
        reset = 1'b0;
        step(1);

        // Basic command; later arg change must not leak through
        pio_cmd_i = 19'h4_2005;
        step(1);
        check("t1_start", 32'(cp_start_o), 32'd1);
        check("t1_op",    32'(cp_op_o),    32'd0);
        check("t1_arg",   32'(cp_arg_o),   32'h2005);
        check("t1_busy",  32'(busy_o),     32'd1);
        pio_cmd_i = 19'h4_7FFF;
        step(1);
        check("t1_start_1cyc", 32'(cp_start_o), 32'd0);
        check("t1_arg_held",   32'(cp_arg_o),   32'h2005);
        step(4);
        check("t1_wait_status", 32'(pio_status_o), 32'h0);
        cp_done_i   = 1'b1;
        cp_result_i = 8'h3C;
        step(1);
        cp_done_i = 1'b0;
        check("t1_status", 32'(pio_status_o), 32'h23C);
        step(1);
        check("t1_done_held", 32'(busy_o), 32'd1);
        pio_cmd_i[18] = 1'b0;
        step(1);
        check("t1_idle",   32'(busy_o),       32'd0);
        check("t1_sticky", 32'(pio_status_o), 32'h23C);
        good_cnt++;

        // Timeout; req dropped during ISSUE; late done ignored
        pio_cmd_i = {1'b1, 3'd1, 15'h0011};
        step(1);
        check("t2_start",   32'(cp_start_o),   32'd1);
        check("t2_cleared", 32'(pio_status_o), 32'h03C);
        pio_cmd_i[18] = 1'b0;
        step(15);
        check("t2_not_yet", 32'(pio_status_o), 32'h03C);
        step(1);
        check("t2_timeout", 32'(pio_status_o), 32'h3FF);
        cp_done_i   = 1'b1;
        cp_result_i = 8'h55;
        step(1);
        cp_done_i = 1'b0;
        check("t2_idle",      32'(busy_o),       32'd0);
        check("t2_late_done", 32'(pio_status_o), 32'h3FF);

        // req held high across reset release must not be accepted
        reset     = 1'b1;
        pio_cmd_i = {1'b1, 3'd2, 15'h0123};
        step(1);
        reset    = 1'b0;
        good_cnt = 0;
        step(3);
        check("t4_no_accept_busy",  32'(busy_o),     32'd0);
        check("t4_no_accept_start", 32'(cp_start_o), 32'd0);
        pio_cmd_i[18] = 1'b0;
        step(1);
        good_cmd(3'd2, 15'h0123, 8'h42, 0);

        // Reset during WAIT; stale done of aborted command ignored
        pio_cmd_i = {1'b1, 3'd3, 15'h00AA};
        step(2);
        check("t5_in_wait", 32'(busy_o), 32'd1);
        reset = 1'b1;
        step(1);
        check("t5_rst_status", 32'(pio_status_o), 32'h0);
        check("t5_rst_outs",   32'({cp_start_o, busy_o, cp_op_o, cp_arg_o}), 32'h0);
        reset       = 1'b0;
        good_cnt    = 0;
        cp_done_i   = 1'b1;
        cp_result_i = 8'h99;
        step(1);
        cp_done_i = 1'b0;
        check("t5_stale_status", 32'(pio_status_o), 32'h0);
        check("t5_stale_busy",   32'(busy_o),       32'd0);
        pio_cmd_i[18] = 1'b0;
        step(1);
        good_cmd(3'd4, 15'h00BB, 8'h5A, 2);

        // Done with err in the exact expiry cycle: coprocessor result wins
        pio_cmd_i = {1'b1, 3'd5, 15'h0000};
        step(1);
        check("t6_start", 32'(cp_start_o), 32'd1);
        step(15);
        check("t6_not_yet", 32'(pio_status_o), 32'h05A);
        cp_done_i   = 1'b1;
        cp_err_i    = 1'b1;
        cp_result_i = 8'h11;
        step(1);
        cp_done_i = 1'b0;
        cp_err_i  = 1'b0;
        check("t6_status", 32'(pio_status_o), 32'h311);
        pio_cmd_i[18] = 1'b0;
        step(1);
        check("t6_idle", 32'(busy_o), 32'd0);

        // Two more good commands, then opcode 7
        good_cmd(3'd6, 15'h0001, 8'h77, 1);
        good_cmd(3'd0, 15'h0002, 8'h88, 0);
        pio_cmd_i = {1'b1, 3'd7, 15'h0000};
        step(1);
        check("t3_no_start", 32'(cp_start_o), 32'd0);
        check("t3_busy",     32'(busy_o),     32'd1);
`ifdef PIO_CMD_COUNT_EN
        check("t3_query", 32'(pio_status_o), 32'h200 | 32'(good_cnt[7:0]));
`else
        check("t3_illegal", 32'(pio_status_o), 32'h300);
`endif
        pio_cmd_i[18] = 1'b0;
        step(1);
        check("t3_idle", 32'(busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pio_cmd_sequencer.md
Name: pio_cmd_sequencer

Overview:
Fabric-side command controller between the HPS PIO conduits and the matrix coprocessor datapath.
- Takes 19-bit command words that the HPS writes to the LED PIO export.
- Issues one command at a time to the coprocessor using a start/done handshake, with a watchdog.
- Returns completion, error and an 8-bit result on the 10-bit switch PIO input, so the HPS polls one register.

Parameters:
TIMEOUT_CYC, 1024, cycles to wait for cp_done_i after cp_start_o before declaring a timeout (legal range 2..65535).
OPC_VALID, 8'b0111_1111, bitmask of legal opcodes; bit k set means opcode k is legal.

Ports:
clk_clk  in  1  system clock, same domain as the PIO exports; rising edge.
reset  in  1  synchronous, active-high reset.
pio_cmd_i  in  19  command word from the LED PIO export: [18] req, [17:15] opcode, [14:0] argument.
pio_status_o  out  10  to the switch PIO export: [9] done, [8] err, [7:0] result.
cp_start_o  out  1  one-cycle start pulse to the coprocessor.
cp_op_o  out  3  opcode to the coprocessor.
cp_arg_o  out  15  argument to the coprocessor.
cp_done_i  in  1  coprocessor completion strobe; honoured only in WAIT.
cp_err_i  in  1  coprocessor error flag, sampled together with cp_done_i.
cp_result_i  in  8  coprocessor result, sampled together with cp_done_i.
busy_o  out  1  high whenever state != IDLE.

Behaviour:
Reset values
- All outputs 0.
- State is IDLE, timer is 0.
- req_q (registered copy of pio_cmd_i[18]) resets to 1, so a req already high when reset releases is not accepted until it drops to 0.

States
- IDLE
  - Accept a command when pio_cmd_i[18]=1 and req_q=0 (rising edge of req).
  - On accept: latch opcode and argument, clear done and err.
  - Legal opcode: go to ISSUE.
  - Illegal opcode (OPC_VALID bit clear): go to DONE with err=1 and result=8'h00; cp_start_o is never asserted.
- ISSUE
  - cp_start_o=1 for exactly this one cycle.
  - cp_op_o and cp_arg_o hold the latched values from ISSUE until WAIT exits.
  - Timer cleared; go to WAIT.
- WAIT
  - Timer increments by 1 each cycle.
  - cp_done_i=1: latch cp_result_i into result and cp_err_i into err; go to DONE.
  - Timer reaches TIMEOUT_CYC-1 with no cp_done_i: err=1, result=8'hFF; go to DONE.
  - cp_done_i in the expiry cycle: done wins and the timeout is ignored.
- DONE
  - done=1.
  - Go to IDLE when pio_cmd_i[18]=0. If req is already low, DONE lasts exactly 1 cycle.
  - done, err and result stay sticky in pio_status_o until the next command is accepted.

Latency
- req edge sampled in cycle N: cp_start_o=1 in cycle N+1.
- cp_done_i in cycle M: pio_status_o[9]=1 in cycle M+1.

Boundary conditions
- req drop during ISSUE or WAIT is ignored; the command completes normally.
- req high throughout DONE blocks re-acceptance. A new command needs req to go 0 then 1.
- Argument or opcode changes on pio_cmd_i after accept have no effect.
- cp_done_i outside WAIT is ignored, including a stale done arriving after a timeout.
- Reset mid-operation: next cycle state is IDLE, cp_start_o=0, status=0, req_q=1.

Optional Feature:
Macro PIO_CMD_COUNT_EN.
- Defined:
  - An 8-bit counter increments on every coprocessor completion with err=0; it wraps 255 to 0.
  - Opcode 3'b111 is an internal query: IDLE goes straight to DONE, result=count, err=0, no cp_start_o.
  - Opcode 7 is legal even if OPC_VALID[7]=0.
- Not defined:
  - No counter is built.
  - Opcode 7 follows OPC_VALID like any other opcode (illegal under the default mask).

Decomposition:
- Package pio_cmd_pkg holds:
  - Constants CMD_W=19, STAT_W=10, OPC_W=3, ARG_W=15, RES_W=8.
  - Field bit indices for the command word and the status word.
  - The state enum (IDLE, ISSUE, WAIT, DONE).
  - Named opcode constants, including OPC_QUERY=3'd7.
- Sub-module cp_watchdog: clear/enable timer, TIMEOUT_CYC parameter, one-cycle expired output.

Test Plan:
- Reset, then cmd=19'h4_2005 (req=1, op=0, arg=0x2005) -> cp_start_o pulses 1 cycle with cp_op_o=0 and cp_arg_o=0x2005; cp_done_i with result 8'h3C after 5 cycles -> pio_status_o=10'h23C next cycle; drop req -> IDLE, busy_o=0.
- Coprocessor never answers, TIMEOUT_CYC=16 -> 16 cycles after the start pulse status=10'h3FF (done=1, err=1, result FF); a late cp_done_i changes nothing.
- Opcode 7 with the macro off -> status=10'h300, no cp_start_o. With the macro on, after 3 good commands -> status=10'h203.
- req held high across reset release -> no accept; toggle req 0 then 1 -> accepted.
- Assert reset during WAIT -> next cycle all outputs 0; cp_done_i of the aborted command ignored; a new command runs cleanly.
- cp_done_i with cp_err_i=1 in the exact timeout-expiry cycle, result 8'h11 -> status=10'h311 (coprocessor result, not FF).
